// File: rtl/sumador_serial.sv
// rtl/sumador_serial.sv - bit-serial adder controller around a 1-bit full-adder cell (optional o_ovf via SERIAL_OVF_EN)

module SumadorCompleto (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sumador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy,
  output logic             o_done
`ifdef SERIAL_OVF_EN
  ,output logic            o_ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic              fa_s;
  logic              fa_co;

  SumadorCompleto u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sequencer: capture operands, shift one bit pair per cycle, publish the result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      o_sum  <= '0;
      o_cout <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
`ifdef SERIAL_OVF_EN
      o_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            a_sr   <= i_a;
            b_sr   <= i_b;
            carry  <= i_cin;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          o_sum <= {fa_s, o_sum[WIDTH-1:1]};
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            o_cout <= fa_co;
`ifdef SERIAL_OVF_EN
            // carry into the MSB is the flop value before this edge
            o_ovf  <= carry ^ fa_co;
`endif
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
